// File: rtl/uart_pkg.sv
// Shared types and helpers for the framed UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {PAR_NONE, PAR_EVEN, PAR_ODD} parity_e;

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} tx_state_e;

  // Bit times per frame: start + payload + optional parity + stop bits.
  function automatic int unsigned frame_len(input int unsigned data_w,
                                            input int unsigned parity,
                                            input int unsigned stop_bits);
    return 32'd1 + data_w + ((parity != 0) ? 32'd1 : 32'd0) + stop_bits;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; rd_data shows the head entry while non-empty.
module uart_sync_fifo #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH),
  localparam int unsigned CNT_W     = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              do_push, do_pop;

  assign full    = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem[rd_ptr_q];

  // A full FIFO refuses the push even when a pop frees a slot this cycle.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_framed.sv
// UART transmitter with configurable width, baud divider, parity and stop bits, fed by a
// small FIFO. tx is registered from the current state, so it trails the FSM by one cycle.
module uart_tx_framed
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned FIFO_DEPTH   = 4,
  localparam int unsigned CNT_W       = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              tx,
  output logic              busy,
  output logic [CNT_W-1:0]  fifo_cnt
);

  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT + 1);
  localparam int unsigned IDX_W  = $clog2(DATA_W + 1);

  localparam logic [BAUD_W-1:0] BaudLast = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]  DataLast = IDX_W'(DATA_W - 1);
  localparam logic [IDX_W-1:0]  StopLast = IDX_W'(STOP_BITS - 1);
  localparam parity_e           ParMode  = parity_e'(PARITY[1:0]);

  tx_state_e         state_q;
  logic [BAUD_W-1:0] baud_q;
  logic [IDX_W-1:0]  bit_idx_q;
  logic [DATA_W-1:0] shift_q;
  logic              par_bit_q;

  logic              fifo_full, fifo_empty, push, pop, baud_tc, frame_end, word_parity;
  logic [DATA_W-1:0] fifo_rd_data;

  assign in_ready = ~fifo_full;
  assign push     = in_valid & in_ready;
  assign baud_tc  = (baud_q == BaudLast);

  // Last cycle of the final stop bit: the next word may start without an idle gap.
  assign frame_end   = (state_q == StStop) & baud_tc & (bit_idx_q == StopLast);
  assign pop         = ~fifo_empty & ((state_q == StIdle) | frame_end);
  assign word_parity = (^fifo_rd_data) ^ (ParMode == PAR_ODD);

  // Both terms are registers and swap at the same edge on a pop, so busy stays high.
  assign busy = (state_q != StIdle) | ~fifo_empty;

  uart_sync_fifo #(
    .DATA_W    (DATA_W),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (push),
    .pop    (pop),
    .wr_data(in_data),
    .rd_data(fifo_rd_data),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      par_bit_q <= 1'b0;
      tx        <= 1'b1;
    end else begin
      if (state_q != StIdle) baud_q <= baud_tc ? '0 : baud_q + BAUD_W'(1);

      unique case (state_q)
        StIdle: begin
          tx        <= 1'b1;
          baud_q    <= '0;
          bit_idx_q <= '0;
          if (pop) begin
            shift_q   <= fifo_rd_data;
            par_bit_q <= word_parity;
            state_q   <= StStart;
          end
        end
        StStart: begin
          tx <= 1'b0;
          if (baud_tc) begin
            bit_idx_q <= '0;
            state_q   <= StData;
          end
        end
        StData: begin
          tx <= shift_q[0];
          if (baud_tc) begin
            shift_q <= shift_q >> 1;
            if (bit_idx_q == DataLast) begin
              bit_idx_q <= '0;
              state_q   <= (ParMode == PAR_NONE) ? StStop : StParity;
            end else begin
              bit_idx_q <= bit_idx_q + IDX_W'(1);
            end
          end
        end
        StParity: begin
          tx <= par_bit_q;
          if (baud_tc) begin
            bit_idx_q <= '0;
            state_q   <= StStop;
          end
        end
        StStop: begin
          tx <= 1'b1;
          if (baud_tc) begin
            if (bit_idx_q == StopLast) begin
              bit_idx_q <= '0;
              if (pop) begin
                shift_q   <= fifo_rd_data;
                par_bit_q <= word_parity;
                state_q   <= StStart;
              end else begin
                state_q <= StIdle;
              end
            end else begin
              bit_idx_q <= bit_idx_q + IDX_W'(1);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifndef SYNTHESIS
  a_idle_line_high: assert property (@(posedge clk) disable iff (rst)
    (state_q == StIdle) |-> tx);
  a_cnt_bounded: assert property (@(posedge clk) fifo_cnt <= CNT_W'(FIFO_DEPTH));
  c_full_with_pop: cover property (@(posedge clk) disable iff (rst) fifo_full && pop);
`endif

endmodule

// File: tb/tb_uart_tx_framed.sv
// Bench for uart_tx_framed: four configurations checked every cycle against a frame-timing
// model, plus directed scenarios with literal expectations.
module tb_uart_tx_framed;

  localparam int NI = 4;

  logic       clk;
  logic       rst;
  logic [3:0] in_valid;
  logic [7:0] in_data [NI];
  logic [3:0] in_ready;
  logic [3:0] tx;
  logic [3:0] busy;
  logic [2:0] fcnt [NI];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  bit armed    = 0;

  // Model: per instance, accepted words with their accept and tx-start cycles.
  int         acc_a [NI][64];
  int         st_a  [NI][64];
  logic [7:0] dat_a [NI][64];
  int         n_w   [NI];

  // Instance 0 default, 1 even parity, 2 odd parity, 3 two stop bits at one clock per bit.
  function automatic int clks(input int i);  return (i == 3) ? 1 : 4; endfunction
  function automatic int par(input int i);   return (i == 1) ? 1 : ((i == 2) ? 2 : 0); endfunction
  function automatic int stops(input int i); return (i == 3) ? 2 : 1; endfunction
  function automatic int fl(input int i);
    return (1 + 8 + ((par(i) != 0) ? 1 : 0) + stops(i)) * clks(i);
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    uart_tx_framed #(
      .DATA_W      (8),
      .CLKS_PER_BIT((g == 3) ? 1 : 4),
      .PARITY      ((g == 1) ? 1 : ((g == 2) ? 2 : 0)),
      .STOP_BITS   ((g == 3) ? 2 : 1),
      .FIFO_DEPTH  (4)
    ) u_dut (
      .clk     (clk),
      .rst     (rst),
      .in_valid(in_valid[g]),
      .in_data (in_data[g]),
      .in_ready(in_ready[g]),
      .tx      (tx[g]),
      .busy    (busy[g]),
      .fifo_cnt(fcnt[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void check(input string nm, input int inst, input int act, input int exp);
    n_checks++;
    if (act != exp)
      $display("FAIL %s inst=%0d cyc=%0d got=%0d expected=%0d", nm, inst, cyc, act, exp);
    else
      n_pass++;
  endfunction

  // Expected line level after edge t.
  function automatic int m_tx(input int i, input int t);
    int         s, b;
    logic [7:0] d;
    for (int k = 0; k < n_w[i]; k++) begin
      s = st_a[i][k];
      if (t >= s && t < s + fl(i)) begin
        b = (t - s) / clks(i);
        d = dat_a[i][k];
        if (b == 0) return 0;
        if (b <= 8) return int'(d[b-1]);
        if (par(i) != 0 && b == 9) return int'((^d) ^ (par(i) == 2));
        return 1;
      end
    end
    return 1;
  endfunction

  // A word sits in the FIFO from its accept edge until the edge before its start bit.
  function automatic int m_cnt(input int i, input int t);
    int c = 0;
    for (int k = 0; k < n_w[i]; k++)
      if (acc_a[i][k] <= t && t < st_a[i][k] - 1) c++;
    return c;
  endfunction

  function automatic int m_busy(input int i, input int t);
    for (int k = 0; k < n_w[i]; k++)
      if (acc_a[i][k] <= t && t < st_a[i][k] + fl(i) - 1) return 1;
    return 0;
  endfunction

  // Model update on every rising edge.
  initial begin
    int s;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        armed = 1;
        for (int i = 0; i < NI; i++) n_w[i] = 0;
      end else begin
        for (int i = 0; i < NI; i++) begin
          if (in_valid[i] && m_cnt(i, cyc - 1) != 4 && n_w[i] < 64) begin
            s = cyc + 2;
            if (n_w[i] > 0 && st_a[i][n_w[i]-1] + fl(i) > s) s = st_a[i][n_w[i]-1] + fl(i);
            acc_a[i][n_w[i]] = cyc;
            st_a[i][n_w[i]]  = s;
            dat_a[i][n_w[i]] = in_data[i];
            n_w[i]++;
          end
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (armed) begin
        for (int i = 0; i < NI; i++) begin
          check("tx", i, int'(tx[i]), m_tx(i, cyc));
          check("busy", i, int'(busy[i]), m_busy(i, cyc));
          check("fifo_cnt", i, int'(fcnt[i]), m_cnt(i, cyc));
          check("in_ready", i, int'(in_ready[i]), (m_cnt(i, cyc) != 4) ? 1 : 0);
        end
      end
    end
  end

  task automatic push_word(input int i, input logic [7:0] d);
    in_valid[i] = 1'b1;
    in_data[i]  = d;
    @(negedge clk);
    in_valid[i] = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy != '0 && n < 600) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", 0, (busy != '0) ? 1 : 0, 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    logic [9:0] pat_a5;
    int         base, nacc, budget;
    int         acc [6];
    logic       r;

    pat_a5   = 10'b1101001010;
    rst      = 1'b1;
    in_valid = '0;
    for (int i = 0; i < NI; i++) in_data[i] = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      check("rst_tx", i, int'(tx[i]), 1);
      check("rst_busy", i, int'(busy[i]), 0);
      check("rst_cnt", i, int'(fcnt[i]), 0);
      check("rst_ready", i, int'(in_ready[i]), 1);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single 0xA5 frame, default configuration.
    push_word(0, 8'hA5);
    base = cyc;
    for (int j = 1; j <= 42; j++) begin
      @(negedge clk);
      if (j == 1) check("a5_pre_start", 0, int'(tx[0]), 1);
      if (j >= 2 && j < 42 && (j - 2) % 4 == 0)
        check("a5_bit", (j - 2) / 4, int'(tx[0]), int'(pat_a5[(j - 2) / 4]));
      if (j == 40) check("a5_busy_late", 0, int'(busy[0]), 1);
      if (j == 41) check("a5_busy_done", 0, int'(busy[0]), 0);
    end
    wait_idle();

    // 0x07 with even and odd parity side by side.
    in_valid[1] = 1'b1; in_data[1] = 8'h07;
    in_valid[2] = 1'b1; in_data[2] = 8'h07;
    @(negedge clk);
    in_valid[1] = 1'b0;
    in_valid[2] = 1'b0;
    for (int j = 1; j <= 46; j++) begin
      @(negedge clk);
      if (j == 38) begin
        check("even_par_bit", 1, int'(tx[1]), 1);
        check("odd_par_bit", 2, int'(tx[2]), 0);
      end
      if (j == 44) begin
        check("par_busy_late", 1, int'(busy[1]), 1);
        check("par_busy_late", 2, int'(busy[2]), 1);
      end
      if (j == 45) begin
        check("par_busy_done", 1, int'(busy[1]), 0);
        check("par_busy_done", 2, int'(busy[2]), 0);
      end
    end
    wait_idle();

    // Six words offered back-to-back into a four-deep FIFO.
    nacc        = 0;
    budget      = 0;
    in_valid[0] = 1'b1;
    in_data[0]  = 8'h11;
    while (nacc < 6 && budget < 200) begin
      r = in_ready[0];
      @(negedge clk);
      budget++;
      if (r) begin
        acc[nacc] = cyc;
        nacc++;
        if (nacc == 5) begin
          check("b2b_full_ready", 0, int'(in_ready[0]), 0);
          check("b2b_full_cnt", 0, int'(fcnt[0]), 4);
        end
        in_data[0] = 8'(8'h11 * (nacc + 1));
      end
    end
    in_valid[0] = 1'b0;
    check("b2b_accepts", 0, nacc, 6);
    for (int k = 0; k < 6; k++)
      if (k < nacc) check("b2b_accept_offset", k, acc[k] - acc[0], (k < 5) ? k : 42);
    wait_idle();

    // Two stop bits at one clock per bit: exactly two high cycles between frames.
    in_valid[3] = 1'b1;
    in_data[3]  = 8'h00;
    @(negedge clk);
    in_data[3]  = 8'h80;
    @(negedge clk);
    in_valid[3] = 1'b0;
    base = cyc - 1;
    for (int j = 2; j <= 16; j++) begin
      @(negedge clk);
      if (j == 10) check("stop2_last_data", 3, int'(tx[3]), 0);
      if (j == 11) check("stop2_first", 3, int'(tx[3]), 1);
      if (j == 12) check("stop2_second", 3, int'(tx[3]), 1);
      if (j == 13) check("stop2_next_start", 3, int'(tx[3]), 0);
    end
    wait_idle();

    // Reset during data bit 3 with more words queued; rst must beat a same-cycle push.
    in_valid[0] = 1'b1;
    in_data[0]  = 8'h00;
    repeat (3) @(negedge clk);
    in_valid[0] = 1'b0;
    base = cyc - 2;
    while (cyc < base + 18) @(negedge clk);
    check("pre_rst_tx_low", 0, int'(tx[0]), 0);
    rst         = 1'b1;
    in_valid[0] = 1'b1;
    in_data[0]  = 8'hFF;
    @(negedge clk);
    check("mid_rst_tx", 0, int'(tx[0]), 1);
    check("mid_rst_busy", 0, int'(busy[0]), 0);
    check("mid_rst_cnt", 0, int'(fcnt[0]), 0);
    check("mid_rst_ready", 0, int'(in_ready[0]), 1);
    rst         = 1'b0;
    in_valid[0] = 1'b0;
    repeat (5) @(negedge clk);
    check("post_rst_idle", 0, int'(busy[0]), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
